// File: rtl/comp_vacc_bank_ctrl_pkg.sv
// Shared types and sizing helpers for the component-tracker vacc bank controller.
package comp_vacc_bank_ctrl_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StAcc  = 1'b1
    } state_e;

    function automatic int unsigned log2_ceil(input int unsigned value);
        return $clog2(value);
    endfunction

    function automatic int unsigned ant_w(input int unsigned n_ants);
        return log2_ceil(n_ants);
    endfunction

    // A zero-bit sample counter still needs one physical bit.
    function automatic int unsigned samp_w(input int unsigned acc_len_bits);
        return (acc_len_bits > 0) ? acc_len_bits : 1;
    endfunction

    function automatic int unsigned win_len(input int unsigned n_ants,
                                            input int unsigned acc_len_bits);
        return n_ants << acc_len_bits;
    endfunction

endpackage

// File: rtl/comp_vacc_bank_ctrl_acc_window_ctr.sv
// Nested sample/antenna counters for one accumulation window, with restart and clear.
module comp_vacc_bank_ctrl_acc_window_ctr
    import comp_vacc_bank_ctrl_pkg::*;
#(
    parameter int unsigned N_ANTS              = 32,
    parameter int unsigned SERIAL_ACC_LEN_BITS = 7
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   restart,
    input  logic                                   advance,
    output logic [samp_w(SERIAL_ACC_LEN_BITS)-1:0] samp_ctr,
    output logic [ant_w(N_ANTS)-1:0]               ant_ctr,
    output logic                                   first,
    output logic                                   win_end
);

    localparam int unsigned SW = samp_w(SERIAL_ACC_LEN_BITS);
    localparam int unsigned AW = ant_w(N_ANTS);
    localparam logic [SW-1:0] SampLast = SW'((1 << SERIAL_ACC_LEN_BITS) - 1);
    localparam logic [AW-1:0] AntLast  = AW'(N_ANTS - 1);

    logic [SW-1:0] samp_q, samp_d, samp_inc;
    logic [AW-1:0] ant_q, ant_d, ant_inc;
    logic          first_q, first_d;
    logic          end_q, end_d;

    always_comb begin
        samp_inc = (samp_q == SampLast) ? '0 : samp_q + 1'b1;
        ant_inc  = (samp_q == SampLast) ? ant_q + 1'b1 : ant_q;

        samp_d  = samp_q;
        ant_d   = ant_q;
        first_d = first_q;
        end_d   = end_q;

        if (clear) begin
            samp_d  = '0;
            ant_d   = '0;
            first_d = 1'b0;
            end_d   = 1'b0;
        end else if (restart) begin
            // N_ANTS >= 2, so the first sample can never also be the window end.
            samp_d  = '0;
            ant_d   = '0;
            first_d = 1'b1;
            end_d   = 1'b0;
        end else if (advance) begin
            samp_d  = samp_inc;
            ant_d   = ant_inc;
            first_d = (samp_inc == '0);
            end_d   = (samp_inc == SampLast) && (ant_inc == AntLast);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q  <= '0;
            ant_q   <= '0;
            first_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            ant_q   <= ant_d;
            first_q <= first_d;
            end_q   <= end_d;
        end
    end

    assign samp_ctr = samp_q;
    assign ant_ctr  = ant_q;
    assign first    = first_q;
    assign win_end  = end_q;

endmodule

// File: rtl/comp_vacc_bank_ctrl.sv
// Write sequencer and ping-pong bank arbiter for the component-tracker vector accumulator.
// Define COMP_VACC_BANK_CTRL_OVR_CNT_EN to build the saturating overrun event counter.
module comp_vacc_bank_ctrl
    import comp_vacc_bank_ctrl_pkg::*;
#(
    parameter int unsigned N_ANTS              = 32,
    parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
    parameter int unsigned OVR_CNT_WIDTH       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      rd_done,
    output logic                      wr_en,
    output logic [ant_w(N_ANTS)-1:0]  wr_addr,
    output logic                      wr_first,
    output logic                      wr_bank,
    output logic                      rd_bank,
    output logic                      rd_vld,
    output logic                      win_done,
    output logic                      overrun,
    output logic [OVR_CNT_WIDTH-1:0]  ovr_cnt
);

    localparam int unsigned SW = samp_w(SERIAL_ACC_LEN_BITS);
    localparam int unsigned AW = ant_w(N_ANTS);

    state_e        state_q, state_d;
    logic          ctr_clear, ctr_restart, ctr_advance;
    logic [SW-1:0] samp_ctr;
    logic [AW-1:0] ant_ctr;
    logic          ctr_first, ctr_win_end;

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          rd_vld_q, rd_vld_d;
    logic          overrun_q, overrun_d;
    logic          ovr_evt;

    comp_vacc_bank_ctrl_acc_window_ctr #(
        .N_ANTS              (N_ANTS),
        .SERIAL_ACC_LEN_BITS (SERIAL_ACC_LEN_BITS)
    ) u_acc_window_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ctr_clear),
        .restart  (ctr_restart),
        .advance  (ctr_advance),
        .samp_ctr (samp_ctr),
        .ant_ctr  (ant_ctr),
        .first    (ctr_first),
        .win_end  (ctr_win_end)
    );

    // The first flag already encodes samp_ctr == 0.
    logic unused_samp_ctr;
    assign unused_samp_ctr = ^samp_ctr;

    always_comb begin
        state_d     = state_q;
        ctr_clear   = 1'b0;
        ctr_restart = 1'b0;
        ctr_advance = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sync && en) begin
                    state_d     = StAcc;
                    ctr_restart = 1'b1;
                end else begin
                    ctr_clear = 1'b1;
                end
            end
            StAcc: begin
                // en only matters at a window boundary; a partial window always finishes.
                if (ctr_win_end && !en) begin
                    state_d   = StIdle;
                    ctr_clear = 1'b1;
                end else if (sync) begin
                    ctr_restart = 1'b1;
                end else begin
                    ctr_advance = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ctr_win_end is only ever set while accumulating, so it doubles as the swap strobe.
    assign ovr_evt = ctr_win_end && rd_vld_q && !rd_done;

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_vld_d  = rd_vld_q;
        overrun_d = overrun_q | ovr_evt;

        if (ctr_win_end) begin
            rd_bank_d = wr_bank_q;
            wr_bank_d = ~wr_bank_q;
            rd_vld_d  = 1'b1;
        end else if (rd_done && rd_vld_q) begin
            rd_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_vld_q  <= rd_vld_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef COMP_VACC_BANK_CTRL_OVR_CNT_EN
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= '0;
        end else if (ovr_evt && !(&ovr_cnt_q)) begin
            ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    assign ovr_cnt = '0;
`endif

    assign wr_en    = (state_q == StAcc);
    assign wr_addr  = ant_ctr;
    assign wr_first = ctr_first;
    assign win_done = ctr_win_end;
    assign wr_bank  = wr_bank_q;
    assign rd_bank  = rd_bank_q;
    assign rd_vld   = rd_vld_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_comp_vacc_bank_ctrl.sv
// Self-checking bench for comp_vacc_bank_ctrl (N_ANTS=4, L=4, 16-cycle windows).
module tb_comp_vacc_bank_ctrl;

    localparam int unsigned NA = 4;
    localparam int unsigned SB = 2;
    localparam int unsigned OW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          sync = 1'b0;
    logic          rd_done = 1'b0;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic          wr_first;
    logic          wr_bank;
    logic          rd_bank;
    logic          rd_vld;
    logic          win_done;
    logic          overrun;
    logic [OW-1:0] ovr_cnt;

    always #5 clk = ~clk;

    comp_vacc_bank_ctrl #(
        .N_ANTS              (NA),
        .SERIAL_ACC_LEN_BITS (SB),
        .OVR_CNT_WIDTH       (OW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .rd_done  (rd_done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_first (wr_first),
        .wr_bank  (wr_bank),
        .rd_bank  (rd_bank),
        .rd_vld   (rd_vld),
        .win_done (win_done),
        .overrun  (overrun),
        .ovr_cnt  (ovr_cnt)
    );

    // Observed outputs: {wr_en, wr_addr, wr_first, win_done, wr_bank, rd_bank, rd_vld, overrun, ovr_cnt}
    logic [24:0] act;
    assign act = {wr_en, wr_addr, wr_first, win_done, wr_bank, rd_bank, rd_vld, overrun, ovr_cnt};

    int checks = 0;
    int errors = 0;
    int cur_scn = -1;
    int cur_cyc = -1;
    bit running = 1'b0;

    typedef struct {
        int resync;
        int rd_done1;
        int rst_at;
        int en_off;
        int sync2;
        int ncyc;
    } scn_t;

    typedef struct {
        int         scn;
        int         cyc;
        logic [8:0] exp;
    } chk_t;

    scn_t scns[6];
    chk_t chks[20];

    logic [24:0] exp_q[$];

    bit m_act, m_wb, m_rb, m_rv, m_ov;
    int m_pos, m_cnt;

    task automatic check(input string name, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s scn=%0d cyc=%0d got=%h exp=%h", name, cur_scn, cur_cyc, got, exp);
        end
    endtask

    function automatic logic [24:0] model_obs();
        logic [24:0] o;
        o = {m_act, 2'(m_pos / 4), m_act && (m_pos % 4 == 0), m_act && (m_pos == 15),
             m_wb, m_rb, m_rv, m_ov, 16'(m_cnt)};
        return o;
    endfunction

    task automatic model_reset();
        m_act = 0; m_wb = 0; m_rb = 0; m_rv = 0; m_ov = 0; m_pos = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    // Advance the window model by one clock using the inputs of the cycle just ending.
    task automatic model_step();
        bit done;
        done = m_act && (m_pos == 15);
        if (done) begin
            if (m_rv && !rd_done) begin
                m_ov = 1;
`ifdef COMP_VACC_BANK_CTRL_OVR_CNT_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
            m_rb = m_wb;
            m_wb = !m_wb;
            m_rv = 1;
        end else if (rd_done) begin
            m_rv = 0;
        end
        if (!m_act) begin
            if (sync && en) begin
                m_act = 1;
                m_pos = 0;
            end
        end else if (done && !en) begin
            m_act = 0;
            m_pos = 0;
        end else if (sync || done) begin
            m_pos = 0;
        end else begin
            m_pos++;
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic run_scn(input int s);
        scn_t sc;
        sc = scns[s];
        cur_cyc = -1;
        cur_scn = s;
        en = 0; sync = 0; rd_done = 0;
        rst_n = 0;
        model_reset();
        running = 1'b1;
        for (int c = 0; c < sc.ncyc; c++) begin
            @(posedge clk);
            if (rst_n) model_step();
            #1;
            cur_cyc = c;
            en      = (c >= 5) && (sc.en_off < 0 || c < sc.en_off);
            sync    = (c == 10) || (c == sc.resync) || (c == sc.sync2);
            rd_done = (c == sc.rd_done1);
            if (c == 3) rst_n = 1;
            if (c == sc.rst_at) begin
                rst_n = 0;
                model_reset();
                #1;
                check("async_rst", act, 25'h0);
            end
            if (sc.rst_at >= 0 && c == sc.rst_at + 3) rst_n = 1;
        end
    endtask

    initial begin
        logic [24:0] exp;
        forever begin
            @(negedge clk);
            if (running) begin
                if (!rst_n || exp_q.size() == 0) exp = 25'h0;
                else exp = exp_q.pop_front();
                check("scoreboard", act, exp);
                for (int i = 0; i < 20; i++) begin
                    if (chks[i].scn == cur_scn && chks[i].cyc == cur_cyc)
                        check("table", {act[24:16], 16'h0}, {chks[i].exp, 16'h0});
                end
            end
        end
    end

    initial begin
        //          resync rd_done rst_at en_off sync2 ncyc
        scns[0] = '{-1,    30,     -1,    -1,    -1,   48};
        scns[1] = '{-1,    -1,     -1,    -1,    -1,   62};
        scns[2] = '{-1,    42,     -1,    -1,    -1,   46};
        scns[3] = '{18,    -1,     -1,    -1,    -1,   38};
        scns[4] = '{-1,    -1,     20,    -1,    32,   36};
        scns[5] = '{-1,    5,      -1,    15,    30,   34};

        // exp = {wr_en, wr_addr, wr_first, win_done, wr_bank, rd_bank, rd_vld, overrun}
        chks[0]  = '{0, 11, 9'b1_00_1_0_0_0_0_0};
        chks[1]  = '{0, 15, 9'b1_01_1_0_0_0_0_0};
        chks[2]  = '{0, 26, 9'b1_11_0_1_0_0_0_0};
        chks[3]  = '{0, 27, 9'b1_00_1_0_1_0_1_0};
        chks[4]  = '{0, 31, 9'b1_01_1_0_1_0_0_0};
        chks[5]  = '{0, 43, 9'b1_00_1_0_0_1_1_0};
        chks[6]  = '{1, 43, 9'b1_00_1_0_0_1_1_1};
        chks[7]  = '{1, 59, 9'b1_00_1_0_1_0_1_1};
        chks[8]  = '{2, 42, 9'b1_11_0_1_1_0_1_0};
        chks[9]  = '{2, 43, 9'b1_00_1_0_0_1_1_0};
        chks[10] = '{3, 19, 9'b1_00_1_0_0_0_0_0};
        chks[11] = '{3, 26, 9'b1_01_0_0_0_0_0_0};
        chks[12] = '{3, 34, 9'b1_11_0_1_0_0_0_0};
        chks[13] = '{3, 35, 9'b1_00_1_0_1_0_1_0};
        chks[14] = '{4, 19, 9'b1_10_1_0_0_0_0_0};
        chks[15] = '{4, 25, 9'b0_00_0_0_0_0_0_0};
        chks[16] = '{4, 33, 9'b1_00_1_0_0_0_0_0};
        chks[17] = '{5, 26, 9'b1_11_0_1_0_0_0_0};
        chks[18] = '{5, 27, 9'b0_00_0_0_1_0_1_0};
        chks[19] = '{5, 31, 9'b0_00_0_0_1_0_1_0};

        #2;
        for (int s = 0; s < 6; s++) run_scn(s);
        @(negedge clk);
        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
